// File: rtl/word_to_dibit_serializer_pkg.sv
// Shared types and helpers for the word-to-dibit serializer.
package word_to_dibit_serializer_pkg;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  localparam logic [1:0] IDLE_SYM_DEFAULT = 2'b00;

  // Counter must hold SYMS..0, so it needs clog2(SYMS+1) bits.
  function automatic int unsigned cnt_width(input int unsigned word_w);
    return $clog2(word_w / 2 + 1);
  endfunction

endpackage

// File: rtl/word_to_dibit_serializer_hold_buf.sv
// One-entry holding register that lets the next word wait while the shifter drains.
module serializer_hold_buf
  import word_to_dibit_serializer_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              hold_vld_o,
  output logic [WORD_W-1:0] hold_data_o,
  output logic              in_ready_o
);

  logic              hold_vld_q, hold_vld_d;
  logic [WORD_W-1:0] hold_data_q, hold_data_d;

  // Push only happens while empty and pop only while full, so they never overlap.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (pop_i) begin
      hold_vld_d = 1'b0;
    end else if (push_i) begin
      hold_vld_d  = 1'b1;
      hold_data_d = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign hold_vld_o  = hold_vld_q;
  assign hold_data_o = hold_data_q;
  assign in_ready_o  = ~hold_vld_q;

endmodule

// File: rtl/word_to_dibit_serializer.sv
// Serializes parallel words into a gap-free stream of 2-bit symbols.
module word_to_dibit_serializer
  import word_to_dibit_serializer_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic [1:0]  IDLE_SYM  = IDLE_SYM_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        data,
  output logic              data_vld,
  output logic              data_last,
  output logic              busy
);

  localparam int unsigned SYMS   = WORD_W / 2;
  localparam int unsigned CW     = cnt_width(WORD_W);
  localparam logic [CW-1:0] SYMS_C = CW'(SYMS);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              hold_vld;
  logic [WORD_W-1:0] hold_data;
  logic              ready;
  logic              push, pop, xfer;
  logic [WORD_W-1:0] sh_adv;
  logic [1:0]        emit;

  serializer_hold_buf #(
    .WORD_W(WORD_W)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(in_data),
    .pop_i      (pop),
    .hold_vld_o (hold_vld),
    .hold_data_o(hold_data),
    .in_ready_o (ready)
  );

  assign xfer   = in_valid & ready;
  assign sh_adv = MSB_FIRST ? {sh_q[WORD_W-3:0], 2'b00} : {2'b00, sh_q[WORD_W-1:2]};
  assign emit   = MSB_FIRST ? sh_q[WORD_W-1 -: 2] : sh_q[1:0];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          sh_d    = in_data;
          cnt_d   = SYMS_C;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != ONE_C) begin
          sh_d  = sh_adv;
          cnt_d = cnt_q - ONE_C;
          push  = xfer;
        end else if (hold_vld) begin
          // Hold full means in_ready is low, so no new transfer competes here.
          sh_d  = hold_data;
          cnt_d = SYMS_C;
          pop   = 1'b1;
        end else if (xfer) begin
          sh_d  = in_data;
          cnt_d = SYMS_C;
        end else begin
          sh_d    = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = ready;
  assign data_vld  = (state_q == ST_SHIFT);
  assign data      = data_vld ? emit : IDLE_SYM;
  assign data_last = data_vld & (cnt_q == ONE_C);
  assign busy      = data_vld | hold_vld;

endmodule

// File: tb/tb_word_to_dibit_serializer.sv
// Scoreboard bench for word_to_dibit_serializer (MSB-first and LSB-first instances side by side).
module tb_word_to_dibit_serializer;

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  localparam logic [1:0] IDLE = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;

  logic       rdy_m, vld_m, last_m, busy_m;
  logic [1:0] data_m;
  logic       rdy_l, vld_l, last_l, busy_l;
  logic [1:0] data_l;

  exp_t q_m[$];
  exp_t q_l[$];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [1:0] exp1_m [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
  logic [1:0] exp1_l [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
  logic [1:0] exp2   [8] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 2'd3, 2'd2};
  logic       rdy2   [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  word_to_dibit_serializer #(
    .WORD_W(8), .MSB_FIRST(1'b1), .IDLE_SYM(2'b00)
  ) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
    .data(data_m), .data_vld(vld_m), .data_last(last_m), .busy(busy_m)
  );

  word_to_dibit_serializer #(
    .WORD_W(8), .MSB_FIRST(1'b0), .IDLE_SYM(2'b00)
  ) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .data(data_l), .data_vld(vld_l), .data_last(last_l), .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected symbols are queued at the accepting edge; reset discards anything pending.
  always @(posedge clk) begin
    if (rst) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (in_valid && rdy_m)
        for (int unsigned k = 0; k < 4; k++)
          q_m.push_back('{sym: in_data[7-2*k -: 2], last: (k == 3)});
      if (in_valid && rdy_l)
        for (int unsigned k = 0; k < 4; k++)
          q_l.push_back('{sym: in_data[2*k +: 2], last: (k == 3)});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (vld_m) begin
        if (q_m.size() == 0) check("m_unexpected_sym", vld_m, 1'b0);
        else begin
          e = q_m.pop_front();
          check("m_sym", data_m, e.sym);
          check("m_last", last_m, e.last);
        end
      end else begin
        check("m_idle_data", data_m, IDLE);
        check("m_idle_last", last_m, 1'b0);
      end
      if (vld_l) begin
        if (q_l.size() == 0) check("l_unexpected_sym", vld_l, 1'b0);
        else begin
          e = q_l.pop_front();
          check("l_sym", data_l, e.sym);
          check("l_last", last_l, e.last);
        end
      end else begin
        check("l_idle_data", data_l, IDLE);
        check("l_idle_last", last_l, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    logic rdy;
    // Reset
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", rdy_m, 1'b1);
    check("rst_vld", vld_m, 1'b0);
    check("rst_busy", busy_m, 1'b0);
    check("rst_last", last_m, 1'b0);
    check("rst_data", data_m, IDLE);

    // Single word pulse
    tick();
    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_vld", vld_m, 1'b1);
      check("t1_data_m", data_m, exp1_m[i]);
      check("t1_data_l", data_l, exp1_l[i]);
      check("t1_last", last_m, (i == 3));
    end
    @(negedge clk);
    check("t1_end_vld", vld_m, 1'b0);
    check("t1_end_data", data_m, IDLE);
    check("t1_end_busy", busy_m, 1'b0);

    // Back-to-back words through the holding buffer
    tick();
    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_data = 8'h1E;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t2_vld", vld_m, 1'b1);
      check("t2_data", data_m, exp2[i]);
      check("t2_ready", rdy_m, rdy2[i]);
      check("t2_last", last_m, (i == 3 || i == 7));
      if (i == 0) begin
        tick();
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("t2_end_vld", vld_m, 1'b0);

    // Bypass: second word offered only while the last symbol is shown
    tick();
    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_valid = 1'b0;
    fork
      begin
        repeat (2) tick();
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 8'h1E;
        tick();
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          check("t4_vld", vld_m, 1'b1);
          check("t4_data", data_m, exp2[i]);
          check("t4_hold_empty", rdy_m, 1'b1);
        end
        @(negedge clk);
        check("t4_end_vld", vld_m, 1'b0);
      end
    join

    // Reset mid-word with the holding buffer full
    tick();
    in_valid = 1'b1; in_data = 8'hB4;
    tick();
    in_data = 8'h1E;
    tick();
    @(negedge clk);
    check("t5_pre_ready", rdy_m, 1'b0);
    check("t5_pre_data", data_m, 2'd3);
    rst = 1'b1; in_data = 8'h5A;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_vld", vld_m, 1'b0);
    check("t5_busy", busy_m, 1'b0);
    check("t5_ready", rdy_m, 1'b1);
    check("t5_vld_l", vld_l, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check("t5_quiet", vld_m, 1'b0);
    end

    // Sustained random words
    tick();
    in_valid = 1'b1; in_data = 8'($urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = rdy_m;
      if (i >= 1) check("t6_no_gap", vld_m, 1'b1);
      tick();
      if (rdy) in_data = 8'($urandom);
    end
    in_valid = 1'b0;
    repeat (20) tick();
    check("t6_drained_m", q_m.size(), 0);
    check("t6_drained_l", q_l.size(), 0);
    check("t6_idle_busy", busy_m, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
